// File: rtl/alu_crypt_sequencer.sv
// alu_crypt_sequencer: drives a shared combinational ALU through XOR / PAR / STEP
// phases so that each plaintext byte is XORed with an LFSR keystream byte.
// Optional feature macro: CRYPT_PARITY_EN (adds the PAR phase that forces
// bit 7 of every output byte to the parity of bits 6:0).
module alu_crypt_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [6:0]       Tap,
  input  logic [6:0]       Seed,
  input  logic [LEN_W-1:0] Length,
  input  logic             InValid,
  output logic             InReady,
  input  logic [7:0]       InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [7:0]       OutData,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       AluOp,
  output logic [7:0]       AluA,
  output logic [7:0]       AluB,
  input  logic [7:0]       AluOut
);

  // ALU opcodes shared with the ALU's definitions
  localparam logic [3:0] kREG_COPY   = 4'h0;
  localparam logic [3:0] kXOR        = 4'h3;
`ifdef CRYPT_PARITY_EN
  localparam logic [3:0] kPARITY_BIT = 4'h8;
`endif
  localparam logic [3:0] kLFSR       = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_XOR,
`ifdef CRYPT_PARITY_EN
    S_PAR,
`endif
    S_STEP,
    S_OUT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       lfsr_state_q, lfsr_state_d;
  logic [6:0]       tap_r_q, tap_r_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_r_q, byte_r_d;
  logic [7:0]       res_r_q, res_r_d;

  // State register; a low Reset_n at an edge aborts any job and clears everything
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      lfsr_state_q <= '0;
      tap_r_q      <= '0;
      cnt_q        <= '0;
      byte_r_q     <= '0;
      res_r_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_state_q <= lfsr_state_d;
      tap_r_q      <= tap_r_d;
      cnt_q        <= cnt_d;
      byte_r_q     <= byte_r_d;
      res_r_q      <= res_r_d;
    end
  end

  // Next-state, datapath capture and ALU drive; outputs are idle unless a phase needs them
  always_comb begin
    state_d      = state_q;
    lfsr_state_d = lfsr_state_q;
    tap_r_d      = tap_r_q;
    cnt_d        = cnt_q;
    byte_r_d     = byte_r_q;
    res_r_d      = res_r_q;
    InReady      = 1'b0;
    OutValid     = 1'b0;
    OutData      = 8'h00;
    Done         = 1'b0;
    Busy         = (state_q != S_IDLE);
    AluOp        = kREG_COPY;
    AluA         = 8'h00;
    AluB         = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Length != '0) begin
            tap_r_d      = Tap;
            lfsr_state_d = Seed;
            cnt_d        = Length;
            state_d      = S_WAIT_IN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_IN: begin
        InReady = 1'b1;
        if (InValid) begin
          byte_r_d = InData;
          state_d  = S_XOR;
        end
      end
      S_XOR: begin
        AluOp   = kXOR;
        AluA    = byte_r_q;
        AluB    = {1'b0, lfsr_state_q};
        res_r_d = AluOut;
`ifdef CRYPT_PARITY_EN
        state_d = S_PAR;
`else
        state_d = S_STEP;
`endif
      end
`ifdef CRYPT_PARITY_EN
      S_PAR: begin
        AluOp   = kPARITY_BIT;
        AluB    = res_r_q;
        res_r_d = AluOut;
        state_d = S_STEP;
      end
`endif
      S_STEP: begin
        AluOp        = kLFSR;
        AluA         = {1'b0, tap_r_q};
        AluB         = {1'b0, lfsr_state_q};
        lfsr_state_d = AluOut[6:0];
        state_d      = S_OUT;
      end
      S_OUT: begin
        OutValid = 1'b1;
        OutData  = res_r_q;
        if (OutReady) begin
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_crypt_sequencer.sv
// Self-checking bench for alu_crypt_sequencer. Models the shared ALU
// combinationally and predicts every output byte from a keystream model.
// Follows CRYPT_PARITY_EN the same way the design does.
module tb_alu_crypt_sequencer;

  localparam logic [3:0] kREG_COPY   = 4'h0;
  localparam logic [3:0] kXOR        = 4'h3;
  localparam logic [3:0] kPARITY_BIT = 4'h8;
  localparam logic [3:0] kLFSR       = 4'h9;
`ifdef CRYPT_PARITY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic [6:0] tap, seed;
  logic [7:0] length;
  logic       inValid, inReady;
  logic [7:0] inData;
  logic       outValid, outReady;
  logic [7:0] outData;
  logic       busy, done;
  logic [3:0] aluOp;
  logic [7:0] aluA, aluB, aluOut;

  int total = 0;
  int bad = 0;
  logic [7:0] plain [0:15];

  alu_crypt_sequencer #(.LEN_W(8)) dut (
    .Clk(clk), .Reset_n(resetN), .Start(start), .Tap(tap), .Seed(seed),
    .Length(length), .InValid(inValid), .InReady(inReady), .InData(inData),
    .OutValid(outValid), .OutReady(outReady), .OutData(outData),
    .Busy(busy), .Done(done), .AluOp(aluOp), .AluA(aluA), .AluB(aluB),
    .AluOut(aluOut)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared combinational ALU
  always_comb begin
    aluOut = aluB;
    case (aluOp)
      kXOR:        aluOut = aluA ^ aluB;
      kPARITY_BIT: aluOut = {^aluB[6:0], aluB[6:0]};
      kLFSR:       aluOut = {1'b0, aluB[5:0], ^(aluA[6:0] & aluB[6:0])};
      default:     aluOut = aluB;
    endcase
  end

  // Global time limit so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Keystream model: next state shifts left and feeds back the tap parity
  function automatic logic [6:0] nextKs(input logic [6:0] t, input logic [6:0] s);
    return {s[5:0], ^(t & s)};
  endfunction

  // Expected ciphertext byte for one plaintext byte and keystream value
  function automatic logic [7:0] encrypt(input logic [7:0] b, input logic [6:0] ks);
    logic [7:0] r;
    r = b ^ {1'b0, ks};
`ifdef CRYPT_PARITY_EN
    r[7] = ^r[6:0];
`endif
    return r;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_inReady"}, inReady, 0);
    checkOutput({tag, "_outValid"}, outValid, 0);
    checkOutput({tag, "_outData"}, outData, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_aluA"}, aluA, 0);
    checkOutput({tag, "_aluB"}, aluB, 0);
    checkOutput({tag, "_aluOp"}, aluOp, kREG_COPY);
  endtask

  task automatic startJob(input logic [6:0] t, input logic [6:0] s, input logic [7:0] len);
    start = 1'b1; tap = t; seed = s; length = len;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", busy, 1);
  endtask

  // Push one byte, check latency, hold off OutReady for `stall` cycles, then accept
  task automatic doByte(input logic [7:0] b, input logic [7:0] exp, input int stall, input bit poke);
    int cyc;
    logic [7:0] held;
    inValid = 1'b1; inData = b;
    cyc = 0;
    while (!inReady && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("in_ready", inReady, 1);
    checkOutput("out_valid_in", outValid, 0);
    @(negedge clk);
    inValid = 1'b0;
    if (poke) begin
      start = 1'b1; seed = ~seed; length = 8'd9;
    end
    cyc = 1;
    while (!outValid && cyc < 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    checkOutput("latency", cyc, LAT);
    checkOutput("out_data", outData, exp);
    checkOutput("in_ready_out", inReady, 0);
    held = outData;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", outValid, 1);
      checkOutput("stall_data", outData, held);
      checkOutput("stall_in_ready", inReady, 0);
      checkOutput("stall_no_step", aluOp, kREG_COPY);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic finishJob();
    checkOutput("done_pulse", done, 1);
    checkOutput("done_out_valid", outValid, 0);
    @(negedge clk);
    checkOutput("done_clear", done, 0);
    checkOutput("busy_fall", busy, 0);
  endtask

  // Run a whole job over plain[0:len-1] and compare with the keystream model
  task automatic applyStimulus(input logic [6:0] t, input logic [6:0] s, input int len,
                               input int stall, input bit poke);
    logic [6:0] ks;
    int st;
    ks = s;
    startJob(t, s, 8'(len));
    for (int i = 0; i < len; i++) begin
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      doByte(plain[i], encrypt(plain[i], ks), st, poke && (i == 0));
      ks = nextKs(t, ks);
    end
    checkOutput("final_lfsr", dut.lfsr_state_q, ks);
    finishJob();
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; tap = '0; seed = '0; length = '0;
    inValid = 1'b0; inData = '0; outReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    resetN = 1'b1;
    @(negedge clk);

    $display("[TB] directed job Tap=60 Seed=01 bytes 41 41");
    plain[0] = 8'h41; plain[1] = 8'h41;
    applyStimulus(7'h60, 7'h01, 2, 0, 1'b0);

    $display("[TB] backpressure of 5 cycles");
    for (int i = 0; i < 3; i++) plain[i] = 8'($urandom);
    applyStimulus(7'h44, 7'h2b, 3, 5, 1'b0);

    $display("[TB] zero length job");
    start = 1'b1; length = 8'd0; seed = 7'h11; tap = 7'h22;
    @(negedge clk);
    start = 1'b0;
    checkOutput("len0_done", done, 1);
    checkOutput("len0_busy", busy, 1);
    checkOutput("len0_in_ready", inReady, 0);
    checkOutput("len0_out_valid", outValid, 0);
    @(negedge clk);
    checkOutput("len0_done_clear", done, 0);
    checkOutput("len0_busy_fall", busy, 0);
    checkOutput("len0_in_ready2", inReady, 0);

    $display("[TB] Start pulsed while busy");
    for (int i = 0; i < 3; i++) plain[i] = 8'($urandom);
    applyStimulus(7'h60, 7'h35, 3, 1, 1'b1);

    $display("[TB] edge keys: Tap=0 and Seed=0");
    for (int i = 0; i < 9; i++) plain[i] = 8'($urandom);
    applyStimulus(7'h00, 7'h7f, 9, -1, 1'b0);
    for (int i = 0; i < 3; i++) plain[i] = 8'($urandom);
    applyStimulus(7'h5a, 7'h00, 3, -1, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 6; j++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) plain[i] = 8'($urandom);
      applyStimulus(7'($urandom), 7'($urandom), len, -1, 1'b0);
    end

    $display("[TB] reset during byte 2 of 4");
    startJob(7'h60, 7'h01, 8'd4);
    doByte(8'h41, encrypt(8'h41, 7'h01), 0, 1'b0);
    inValid = 1'b1; inData = 8'h41;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkResetOutputs("midjob_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("no_done_after_reset", done, 0);
    end
    plain[0] = 8'h41;
    applyStimulus(7'h60, 7'h01, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_crypt_sequencer.md
# alu_crypt_sequencer

Multi-cycle controller that sequences the shared combinational ALU to encrypt a byte stream with an LFSR keystream, plus an optional parity bit. It sits between the message buffer (byte producer) and the result store (byte consumer). It drives the ALU's opcode and operand inputs, captures the ALU result each phase, and handles ready/valid handshakes on both sides. One byte costs one ALU operation per phase.

## Interface
Parameters:
- LEN_W, 8, width of the byte-count input and internal counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Start  input  1  begin a job; sampled only in IDLE.
- Tap  input  7  LFSR tap mask, captured at Start.
- Seed  input  7  initial LFSR state, captured at Start.
- Length  input  LEN_W  number of bytes in the job, captured at Start.
- InValid / InReady  input / output  1 / 1  plaintext byte handshake.
- InData  input  8  plaintext byte.
- OutValid / OutReady  output / input  1 / 1  result byte handshake.
- OutData  output  8  encrypted byte.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse when a job completes.
- AluOp  output  4  opcode to the ALU, using the op names from the definitions package.
- AluA, AluB  output  8 / 8  ALU operands.
- AluOut  input  8  ALU result (combinational, same cycle).

## Operation
- Registers: lfsr_state[6:0], tap_r[6:0], cnt[LEN_W-1:0], byte_r[7:0], res_r[7:0].
- IDLE:
  - Start=1 and Length!=0: load tap_r=Tap, lfsr_state=Seed, cnt=Length, then go to WAIT_IN.
  - Start=1 and Length==0: go to DONE.
- WAIT_IN:
  - InReady=1.
  - On InValid: byte_r=InData, then go to XOR.
- XOR:
  - Drive AluOp=kXOR, AluA=byte_r, AluB={1'b0,lfsr_state}.
  - res_r=AluOut.
  - Next state is PAR, or STEP when the parity feature is compiled out.
- PAR:
  - Drive AluOp=kPARITY_BIT, AluB=res_r, AluA=0.
  - res_r=AluOut, which is {^res_r[6:0], res_r[6:0]}.
  - Go to STEP.
- STEP:
  - Drive AluOp=kLFSR, AluA={1'b0,tap_r}, AluB={1'b0,lfsr_state}.
  - lfsr_state=AluOut[6:0], which is {state[5:0], ^(tap&state)}.
  - Go to OUT.
- OUT:
  - OutValid=1, OutData=res_r.
  - On OutReady: cnt=cnt-1. If cnt==1, go to DONE; otherwise go to WAIT_IN.
- DONE:
  - Done=1 for one cycle, then go to IDLE.
- Outside XOR/PAR/STEP: AluOp=kREG_COPY, AluA=AluB=0.
- Start while Busy is ignored; Tap, Seed and Length are not re-sampled mid-job.
- Tap=0 is legal: the LFSR shifts in 0s and the keystream reaches 0 after 7 steps.
- Seed=0 is legal: the keystream stays 0 and the bytes pass through (parity still applied).
- The ALU's Zero and Negative flags are not used.

## Timing
- Reset_n=0 at an edge puts the block in IDLE. That edge clears all registers; no partial byte is emitted.
  - All outputs read 0 after reset (InReady, OutValid, OutData, Busy, Done, AluA, AluB), except AluOp=kREG_COPY.
  - Reset mid-job aborts the job; Done does not pulse.
- Latency with parity: OutValid rises 4 cycles after the InValid&InReady edge (XOR, PAR, STEP, then OUT).
  - Minimum throughput: 5 cycles per byte.
- Latency without parity: 3 cycles; throughput 4 cycles per byte.
- Busy rises the cycle after the accepted Start. Busy falls the cycle after Done.
- OutData holds stable while OutValid=1 and OutReady=0.
- InReady and OutValid are never high in the same cycle.
- Length=0: Done pulses 1 cycle after Start and no bytes are exchanged.
- The cnt wrap boundary is never reached: the transition to DONE happens on cnt==1.

## Configuration
- CRYPT_PARITY_EN defined:
  - PAR state is present.
  - OutData[7] is the parity of res_r[6:0].
- CRYPT_PARITY_EN undefined:
  - PAR state is removed; XOR goes directly to STEP.
  - OutData = InData ^ {1'b0, keystream}, so bit 7 passes through unchanged.
  - kPARITY_BIT is never issued.

## Test plan
- Parity enabled: Tap=7'h60, Seed=7'h01, Length=2, input 8'h41, 8'h41, OutReady=1 -> OutData 8'hC0 then 8'hC3; Done pulses once; final lfsr_state=7'h04.
- Parity disabled, same stimulus -> OutData 8'h40 then 8'h43. Cycles from the second accept to OutValid = 3.
- Backpressure: hold OutReady=0 for 5 cycles in OUT -> OutValid and OutData stay stable, InReady=0, and no LFSR step occurs. Releasing OutReady resumes with the correct next byte.
- Length=0 Start -> Done pulses at the next cycle; InReady and OutValid never assert.
- Start pulsed while Busy with a different Seed -> ignored; the output sequence matches the original Seed.
- Reset_n=0 during PAR of byte 2 of 4 -> the next cycle has all outputs at reset values and no Done. A new job with Seed=7'h01 reproduces 8'hC0 as its first byte.
